// File: rtl/data_stream_cache_if.sv
// data_stream_cache_if: burst-read bus between the cache (master) and external memory (slave)
//   rd_req/rd_addr/rd_len : burst request, held until rd_ack
//   rd_ack                : request accepted
//   rd_valid/rd_data      : data beat
//   rd_last               : final beat of the burst
interface data_stream_cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16
);
    localparam int BURST_WIDTH = $clog2(BURST_LEN + 1);
    logic                   rd_req;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [BURST_WIDTH-1:0] rd_len;
    logic                   rd_ack;
    logic                   rd_valid;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_last;
    modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_valid, rd_data, rd_last);
    modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_valid, rd_data, rd_last);
endinterface

// File: rtl/data_stream_cache.sv
// data_stream_cache: fetches one LENGTH_ARRAY-word block over a burst-read bus and serves it by index
//   clk, rst (async, active-low)
//   start/base_addr : open a new block at base_addr (IDLE only); busy high while fetching
//   DataRequest     : hash stage asks for data; CacheEnough once the whole block is resident
//   index/DataStream: registered buffer read, 1-cycle latency, 0 for out-of-range index
//   rd              : burst-read master port; proto_err is a sticky protocol-error flag
module data_stream_cache #(
    parameter int LENGTH_ARRAY     = 100,
    parameter int DATA_INDEX_WIDTH = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int BURST_LEN        = 16,
    localparam int LENGTH_ARRAY_WIDTH_BIT = $clog2(LENGTH_ARRAY),
    localparam int CNT_WIDTH              = $clog2(LENGTH_ARRAY + 1),
    localparam int BURST_WIDTH            = $clog2(BURST_LEN + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    output logic                             busy,
    input  logic                             DataRequest,
    output logic                             CacheEnough,
    input  logic [LENGTH_ARRAY_WIDTH_BIT-1:0] index,
    output logic [DATA_INDEX_WIDTH-1:0]      DataStream,
    output logic                             proto_err,
    data_stream_cache_if.master              rd
);
    typedef enum logic [1:0] {IDLE, ISSUE, RECEIVE} state_t;
    state_t                      state;
    logic [DATA_INDEX_WIDTH-1:0] mem [LENGTH_ARRAY];
    logic [CNT_WIDTH-1:0]        fill_cnt;
    logic [BURST_WIDTH-1:0]      beat_cnt, rd_len_q, rd_len_nxt;
    logic [ADDR_WIDTH-1:0]       cur_base, rd_addr_q;
    logic [31:0]                 remain;
    logic                        rd_req_q, wr_en, burst_end;
    assign remain     = 32'(LENGTH_ARRAY) - 32'(fill_cnt);
    assign rd_len_nxt = remain > 32'(BURST_LEN) ? BURST_WIDTH'(BURST_LEN) : BURST_WIDTH'(remain);
    // a beat is only stored while the current burst still owes beats and the block has room
    assign wr_en      = state == RECEIVE && rd.rd_valid && beat_cnt < rd_len_q && 32'(fill_cnt) < 32'(LENGTH_ARRAY);
    assign burst_end  = rd.rd_last || beat_cnt + BURST_WIDTH'(1) == rd_len_q;
    assign busy       = state != IDLE;
    assign rd.rd_req  = rd_req_q;
    assign rd.rd_addr = rd_addr_q;
    assign rd.rd_len  = rd_len_q;
    always_ff @(posedge clk) begin
        if (wr_en) mem[LENGTH_ARRAY_WIDTH_BIT'(fill_cnt)] <= rd.rd_data;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            CacheEnough <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            rd_len_q    <= '0;
            DataStream  <= '0;
            proto_err   <= 1'b0;
            fill_cnt    <= '0;
            beat_cnt    <= '0;
            cur_base    <= '0;
        end else begin
            DataStream <= {1'b0, index} < (LENGTH_ARRAY_WIDTH_BIT + 1)'(LENGTH_ARRAY) ? mem[index] : '0;
            // any beat that is not stored is a protocol violation (stray or excess)
            if (rd.rd_valid && !wr_en) proto_err <= 1'b1;
            if (wr_en) begin
                fill_cnt <= fill_cnt + CNT_WIDTH'(1);
                beat_cnt <= beat_cnt + BURST_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_base    <= base_addr;
                        fill_cnt    <= '0;
                        CacheEnough <= 1'b0;
                    end else if (DataRequest && !CacheEnough && 32'(fill_cnt) < 32'(LENGTH_ARRAY)) begin
                        state     <= ISSUE;
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= cur_base + ADDR_WIDTH'(fill_cnt) * ADDR_WIDTH'(DATA_INDEX_WIDTH / 8);
                        rd_len_q  <= rd_len_nxt;
                    end
                end
                ISSUE: begin
                    if (rd.rd_ack) begin
                        rd_req_q <= 1'b0;
                        beat_cnt <= '0;
                        state    <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (wr_en && burst_end) begin
                        state       <= IDLE;
                        CacheEnough <= fill_cnt + CNT_WIDTH'(1) == CNT_WIDTH'(LENGTH_ARRAY);
                    end else if (rd.rd_valid && !wr_en) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_stream_cache.sv
// tb_data_stream_cache: scoreboard bench for data_stream_cache with a scripted burst-memory model
module tb_data_stream_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        busy, cache_enough, proto_err;
    logic        data_request = 1'b0;
    logic [6:0]  index = '0;
    logic [31:0] data_stream;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] cur_base_tb = '0;
    logic [31:0] tag = '0;
    logic [31:0] exp_addr_q[$];
    logic [4:0]  exp_len_q[$];
    logic [31:0] exp_read_q[$];

    data_stream_cache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(16)) rd_if ();

    data_stream_cache dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .busy(busy),
        .DataRequest(data_request), .CacheEnough(cache_enough), .index(index),
        .DataStream(data_stream), .proto_err(proto_err), .rd(rd_if)
    );

    always #5 clk = ~clk;

    initial begin
        rd_if.rd_ack = 1'b0;
        rd_if.rd_valid = 1'b0;
        rd_if.rd_data = '0;
        rd_if.rd_last = 1'b0;
    end

    task automatic do_reset();
        data_request = 1'b0;
        start = 1'b0;
        index = '0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [31:0] t);
        base_addr = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cur_base_tb = base;
        tag = t;
    endtask

    task automatic read_check(input logic [6:0] idx, input logic [31:0] exp);
        logic [31:0] e;
        index = idx;
        exp_read_q.push_back(exp);
        @(posedge clk); #1;
        e = exp_read_q.pop_front();
        vectors++;
        if (data_stream !== e) begin
            miscompares++;
            $display("FAIL read[%0d] got %h expected %h", idx, data_stream, e);
        end
    endtask

    // waits for a request, checks it against the scoreboard, acks after ack_delay cycles,
    // then drives nbeats beats (rd_last on beat last_at, 0 = never); beats past the expected
    // length carry a poison word
    task automatic serve_burst(input int ack_delay, input int nbeats, input int last_at);
        logic [31:0] ea;
        logic [4:0]  el;
        int          t;
        int          w0;
        ea = exp_addr_q.pop_front();
        el = exp_len_q.pop_front();
        t = 0;
        while (rd_if.rd_req !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        vectors++;
        if (rd_if.rd_req !== 1'b1) begin
            miscompares++;
            $display("FAIL burst_timeout got rd_req=%b expected 1 (addr %h)", rd_if.rd_req, ea);
            return;
        end
        vectors++;
        if (rd_if.rd_addr !== ea || rd_if.rd_len !== el) begin
            miscompares++;
            $display("FAIL burst_req got %h/%0d expected %h/%0d", rd_if.rd_addr, rd_if.rd_len, ea, el);
        end
        for (int i = 0; i < ack_delay; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (rd_if.rd_req !== 1'b1 || rd_if.rd_addr !== ea || rd_if.rd_len !== el || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL burst_hold cycle %0d got req=%b %h/%0d expected 1 %h/%0d",
                         i, rd_if.rd_req, rd_if.rd_addr, rd_if.rd_len, ea, el);
            end
        end
        rd_if.rd_ack = 1'b1;
        @(posedge clk); #1;
        rd_if.rd_ack = 1'b0;
        vectors++;
        if (rd_if.rd_req !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL after_ack got req=%b busy=%b expected 0 1", rd_if.rd_req, busy);
        end
        w0 = int'((ea - cur_base_tb) >> 2);
        for (int b = 1; b <= nbeats; b++) begin
            rd_if.rd_valid = 1'b1;
            rd_if.rd_data = (b <= int'(el)) ? tag + 32'(w0 + b - 1) : 32'hDEAD_BEEF;
            rd_if.rd_last = (b == last_at);
            @(posedge clk); #1;
        end
        rd_if.rd_valid = 1'b0;
        rd_if.rd_last = 1'b0;
    endtask

    task automatic fill_rest(input int from);
        int w;
        int l;
        w = from;
        while (w < 100) begin
            l = (100 - w > 16) ? 16 : 100 - w;
            exp_addr_q.push_back(cur_base_tb + 32'(4 * w));
            exp_len_q.push_back(5'(l));
            serve_burst(0, l, l);
            w += l;
        end
        vectors++;
        if (cache_enough !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_done got CacheEnough=%b expected 1", cache_enough);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, cache_enough, rd_if.rd_req, proto_err} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b expected 0000", {busy, cache_enough, rd_if.rd_req, proto_err});
        end
        vectors++;
        if (rd_if.rd_addr !== 32'h0 || rd_if.rd_len !== 5'd0 || data_stream !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_regs got %h/%0d/%h expected 0/0/0", rd_if.rd_addr, rd_if.rd_len, data_stream);
        end
        do_reset();
    endtask

    task automatic test_fill();
        do_reset();
        do_start(32'h1000, 32'hA000);
        data_request = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_addr_q.push_back(32'h1000 + 32'(64 * k));
            exp_len_q.push_back(5'd16);
            serve_burst(0, 16, 16);
        end
        vectors++;
        if (cache_enough !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_early got CacheEnough=%b expected 0", cache_enough);
        end
        exp_addr_q.push_back(32'h1180);
        exp_len_q.push_back(5'd4);
        serve_burst(0, 4, 4);
        vectors++;
        if (cache_enough !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_rise got CacheEnough=%b expected 1", cache_enough);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (rd_if.rd_req !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_quiet got req=%b busy=%b expected 0 0", rd_if.rd_req, busy);
        end
        read_check(7'd37, 32'hA025);
        read_check(7'd0, 32'hA000);
        read_check(7'd99, 32'hA063);
        read_check(7'd100, 32'h0);
        read_check(7'd127, 32'h0);
        data_request = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        do_start(32'h3000, 32'hD000);
        data_request = 1'b1;
        exp_addr_q.push_back(32'h3000);
        exp_len_q.push_back(5'd16);
        serve_burst(5, 16, 16);
        fill_rest(16);
        read_check(7'd20, 32'hD014);
        data_request = 1'b0;
    endtask

    task automatic test_short_burst();
        do_reset();
        do_start(32'h5000, 32'h7000);
        data_request = 1'b1;
        exp_addr_q.push_back(32'h5000);
        exp_len_q.push_back(5'd16);
        serve_burst(0, 10, 10);
        fill_rest(10);
        read_check(7'd9, 32'h7009);
        read_check(7'd10, 32'h700A);
        read_check(7'd99, 32'h7063);
        data_request = 1'b0;
    endtask

    task automatic test_excess();
        do_reset();
        do_start(32'h6000, 32'h8000);
        data_request = 1'b1;
        exp_addr_q.push_back(32'h6000);
        exp_len_q.push_back(5'd16);
        serve_burst(0, 17, 17);
        vectors++;
        if (proto_err !== 1'b1) begin
            miscompares++;
            $display("FAIL excess_err got proto_err=%b expected 1", proto_err);
        end
        fill_rest(16);
        vectors++;
        if (proto_err !== 1'b1) begin
            miscompares++;
            $display("FAIL excess_sticky got proto_err=%b expected 1", proto_err);
        end
        rd_if.rd_valid = 1'b1;
        rd_if.rd_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rd_if.rd_valid = 1'b0;
        vectors++;
        if (cache_enough !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_state got CacheEnough=%b busy=%b expected 1 0", cache_enough, busy);
        end
        read_check(7'd15, 32'h800F);
        read_check(7'd16, 32'h8010);
        read_check(7'd99, 32'h8063);
        read_check(7'd0, 32'h8000);
        data_request = 1'b0;
    endtask

    task automatic test_stray_idle();
        do_reset();
        vectors++;
        if (proto_err !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_pre got proto_err=%b expected 0", proto_err);
        end
        rd_if.rd_valid = 1'b1;
        rd_if.rd_data = 32'h1234_5678;
        @(posedge clk); #1;
        rd_if.rd_valid = 1'b0;
        vectors++;
        if (proto_err !== 1'b1) begin
            miscompares++;
            $display("FAIL stray_idle got proto_err=%b expected 1", proto_err);
        end
    endtask

    task automatic test_request_drop();
        do_reset();
        do_start(32'h4000, 32'hC000);
        data_request = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_addr_q.push_back(32'h4000 + 32'(64 * k));
            exp_len_q.push_back(5'd16);
            serve_burst(0, 16, 16);
        end
        data_request = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (rd_if.rd_req !== 1'b0 || busy !== 1'b0 || cache_enough !== 1'b0) begin
                miscompares++;
                $display("FAIL drop_idle cycle %0d got req=%b busy=%b ce=%b expected 0 0 0",
                         i, rd_if.rd_req, busy, cache_enough);
            end
        end
        data_request = 1'b1;
        fill_rest(32);
        read_check(7'd32, 32'hC020);
        read_check(7'd31, 32'hC01F);
        data_request = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        do_start(32'h1000, 32'hA000);
        data_request = 1'b1;
        exp_addr_q.push_back(32'h1000);
        exp_len_q.push_back(5'd16);
        serve_burst(0, 5, 0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy got busy=%b expected 1", busy);
        end
        data_request = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, cache_enough, rd_if.rd_req, proto_err} !== 4'b0) begin
            miscompares++;
            $display("FAIL async_flags got %b expected 0000", {busy, cache_enough, rd_if.rd_req, proto_err});
        end
        vectors++;
        if (rd_if.rd_addr !== 32'h0 || rd_if.rd_len !== 5'd0 || data_stream !== 32'h0) begin
            miscompares++;
            $display("FAIL async_regs got %h/%0d/%h expected 0/0/0", rd_if.rd_addr, rd_if.rd_len, data_stream);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        rd_if.rd_valid = 1'b1;
        rd_if.rd_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rd_if.rd_valid = 1'b0;
        vectors++;
        if (proto_err !== 1'b1) begin
            miscompares++;
            $display("FAIL late_beat got proto_err=%b expected 1", proto_err);
        end
        do_start(32'h2000, 32'hB000);
        data_request = 1'b1;
        fill_rest(0);
        read_check(7'd5, 32'hB005);
        read_check(7'd99, 32'hB063);
        data_request = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_short_burst();
        test_excess();
        test_stray_idle();
        test_request_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/data_stream_cache.md
Name: data_stream_cache

Overview:
- Upstream feeder of the hash-build stage.
- Answers the hash stage's DataRequest by fetching one block of LENGTH_ARRAY data words from external memory over a simple burst-read interface into a local buffer.
- Asserts CacheEnough once the block is resident.
- Serves DataStream for the index presented by the hash stage, with fixed 1-cycle read latency.

Parameters:
- LENGTH_ARRAY, 100: words per block; must match the hash stage.
- DATA_INDEX_WIDTH, 32: data word width.
- ADDR_WIDTH, 32: external byte-address width.
- BURST_LEN, 16: maximum beats per read burst (>=1).
- Derived localparams:
  - LENGTH_ARRAY_WIDTH_BIT = log2(LENGTH_ARRAY)
  - CNT_WIDTH = log2(LENGTH_ARRAY+1)
  - BURST_WIDTH = log2(BURST_LEN+1)

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- start  in  1  pulse: begin a new block at base_addr.
- base_addr  in  ADDR_WIDTH  byte address of word 0; sampled on accepted start.
- busy  out  1  high in ISSUE/RECEIVE.
- DataRequest  in  1  fetch request from the hash stage.
- CacheEnough  out  1  block fully resident.
- index  in  LENGTH_ARRAY_WIDTH_BIT  word select from the hash stage.
- DataStream  out  DATA_INDEX_WIDTH  registered buffer word.
- rd_req  out  1  burst request; held until rd_ack.
- rd_addr  out  ADDR_WIDTH  burst start address.
- rd_len  out  BURST_WIDTH  beats requested.
- rd_ack  in  1  request accepted.
- rd_valid  in  1  data beat valid.
- rd_data  in  DATA_INDEX_WIDTH  beat data.
- rd_last  in  1  final beat of the burst.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - CacheEnough=0, busy=0, rd_req=0, rd_addr=0, rd_len=0, DataStream=0, proto_err=0.
  - fill_cnt=0, beat_cnt=0, cur_base=0.
  - Buffer contents are undefined.
- Reset mid-burst abandons the burst. Late rd_valid beats after reset release arrive in IDLE and set proto_err.
- start, accepted only in IDLE:
  - Latches cur_base=base_addr.
  - Clears fill_cnt and CacheEnough.
  - Does not by itself fetch.
- start in ISSUE/RECEIVE is ignored (no error).
- States:
  - IDLE: if DataRequest && !CacheEnough && fill_cnt<LENGTH_ARRAY, go to ISSUE next cycle.
    - rd_addr = cur_base + fill_cnt*(DATA_INDEX_WIDTH/8).
    - rd_len = min(BURST_LEN, LENGTH_ARRAY-fill_cnt).
    - rd_req=1.
  - ISSUE: hold rd_req/rd_addr/rd_len stable until rd_ack=1. On the ack cycle: rd_req<=0, beat_cnt<=0, go to RECEIVE.
  - RECEIVE: each rd_valid writes rd_data to buf[fill_cnt], then fill_cnt++ and beat_cnt++.
    - On rd_valid&&rd_last, or when beat_cnt reaches rd_len:
      - If fill_cnt (after the increment) == LENGTH_ARRAY: CacheEnough<=1, go to IDLE.
      - Else: go back to IDLE; the next burst is issued only if DataRequest is still high.
- Short burst (rd_last before rd_len beats): accepted. The next burst resumes at the new fill_cnt.
- Excess beats:
  - A beat arriving after rd_len beats in the same burst, or any rd_valid in IDLE/ISSUE, is dropped and sets proto_err.
  - fill_cnt never exceeds LENGTH_ARRAY.
- A beat with rd_last arriving exactly at rd_len is normal.
- CacheEnough stays 1 until the next accepted start, or reset. The hash stage may re-read any index indefinitely.
- Read port:
  - DataStream <= buf[index] every cycle; 1-cycle latency, independent of state.
  - index >= LENGTH_ARRAY gives DataStream <= 0.
  - Reads of words not yet filled return undefined data (not checked).
- Simultaneous write to buf[fill_cnt] and read of the same index returns the old (pre-write) word.
- busy = (state==ISSUE || state==RECEIVE).
- Address arithmetic is modulo 2^ADDR_WIDTH (wrap allowed, no error).

Test Plan:
- Fill with bursts: reset, start with base_addr=0x1000, hold DataRequest, memory model returns word i = 0xA000+i.
  - Required: bursts at 0x1000/16, 0x1040/16, ..., 0x1180/4 (7 bursts).
  - CacheEnough rises the cycle after the last beat.
  - index=37 gives DataStream=0xA025 one cycle later.
- rd_ack backpressure: delay rd_ack 5 cycles -> rd_req, rd_addr and rd_len stay stable for all 5 cycles; no beat is accepted early.
- Short burst: rd_last on beat 10 of a 16-beat request -> next rd_addr = base+40, rd_len=16; final CacheEnough still after 100 words.
- Excess beat / stray beat: 17th rd_valid in a 16-beat burst -> dropped, proto_err=1 sticky; rd_valid in IDLE also sets it. Buffer contents are unchanged.
- DataRequest dropped mid-block: deassert after burst 2 -> no further rd_req, CacheEnough stays 0; reassert -> fetch resumes at base+128.
- Async reset mid-RECEIVE: rst=0 for 1 cycle -> all outputs 0 immediately, without waiting for a clock edge. New start at 0x2000 refetches from word 0.
